// File: rtl/drv_ad56x3.sv
// rtl/drv_ad56x3.sv - AD5663-family DAC driver fed from Avalon-MM registers or two Avalon-ST sinks
// Once both channel samples are pending, frame A, a dacSync gap, frame B and one idle period are sent.
`timescale 1ns/1ps
module drv_ad56x3 #(
  parameter string SIGN_A        = "UNSIGNED",
  parameter string SIGN_B        = "UNSIGNED",
  parameter int    DATA_WIDTH    = 16,
  parameter int    SCLK_DIVIDER  = 2,
  parameter int    SYNC_DURATION = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            avsAdr,
  input  logic                  avsWr,
  input  logic [15:0]           avsWrData,
  input  logic                  avsRd,
  output logic [15:0]           avsRdData,
  input  logic                  asiValid0,
  input  logic [DATA_WIDTH-1:0] asiData0,
  output logic                  asiRdy0,
  input  logic                  asiValid1,
  input  logic [DATA_WIDTH-1:0] asiData1,
  output logic                  asiRdy1,
  output logic                  dacSync,
  output logic                  dacSclk,
  output logic                  dacDin
);

  localparam bit INV_A   = (SIGN_A == "SIGNED");
  localparam bit INV_B   = (SIGN_B == "SIGNED");
  localparam int DIV_W   = $clog2(SCLK_DIVIDER);
  localparam int CNT_MAX = (SYNC_DURATION > 24) ? SYNC_DURATION : 24;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_FRAME_A, S_GAP, S_FRAME_B, S_TAIL} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [23:0]           sr_q, sr_d;
  logic                  src_q, src_d;
  logic                  pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic [15:0]           rd_q, rd_d;
  logic                  sync_q, sync_d, sclk_q, sclk_d, din_q, din_d;
  logic                  busy, period_end, last_period, in_frame_d;
  logic [23:0]           frame_a, frame_b;
  int                    period_len;

  // Offset-binary conversion for signed channels, then left-justify into 16 bits.
  function automatic logic [15:0] justify(input logic [DATA_WIDTH-1:0] s, input bit inv);
    logic [DATA_WIDTH-1:0] t;
    t = s;
    t[DATA_WIDTH-1] = s[DATA_WIDTH-1] ^ inv;
    return 16'(t) << (16 - DATA_WIDTH);
  endfunction

  assign frame_a = {8'b00_000_000, justify(data_a_q, INV_A)};
  assign frame_b = {8'b00_010_001, justify(data_b_q, INV_B)};

  assign busy    = (state_q != S_IDLE);
  assign asiRdy0 = !src_q && !pend_a_q && !busy;
  assign asiRdy1 = !src_q && !pend_b_q && !busy;

  always_comb begin
    period_len = 1;
    case (state_q)
      S_FRAME_A, S_FRAME_B: period_len = 24;
      S_GAP:                period_len = SYNC_DURATION;
      default:              period_len = 1;
    endcase
  end

  assign period_end  = (div_q == DIV_W'(SCLK_DIVIDER - 1));
  assign last_period = (cnt_q == CNT_W'(period_len - 1));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    src_d    = src_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    rd_d     = '0;

    if (avsRd) begin
      case (avsAdr)
        3'd0:    rd_d = {15'd0, src_q};
        3'd3:    rd_d = {15'd0, busy};
        default: rd_d = '0;
      endcase
    end

    // Sample writes are dropped while busy: the pending slots are cleared at the end anyway.
    if (avsWr) begin
      case (avsAdr)
        3'd0: src_d = avsWrData[0];
        3'd1: if (src_q && !busy) begin
          data_a_d = avsWrData[DATA_WIDTH-1:0];
          pend_a_d = 1'b1;
        end
        3'd2: if (src_q && !busy) begin
          data_b_d = avsWrData[DATA_WIDTH-1:0];
          pend_b_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (asiValid0 && asiRdy0) begin
      data_a_d = asiData0;
      pend_a_d = 1'b1;
    end
    if (asiValid1 && asiRdy1) begin
      data_b_d = asiData1;
      pend_b_d = 1'b1;
    end

    if (state_q == S_IDLE) begin
      if (pend_a_q && pend_b_q) begin
        state_d = S_FRAME_A;
        div_d   = '0;
        cnt_d   = '0;
        sr_d    = frame_a;
      end
    end else if (period_end) begin
      div_d = '0;
      cnt_d = cnt_q + CNT_W'(1);
      sr_d  = {sr_q[22:0], 1'b0};
      if (last_period) begin
        cnt_d = '0;
        case (state_q)
          S_FRAME_A: begin
            if (SYNC_DURATION > 0) begin
              state_d = S_GAP;
            end else begin
              state_d = S_FRAME_B;
              sr_d    = frame_b;
            end
          end
          S_GAP: begin
            state_d = S_FRAME_B;
            sr_d    = frame_b;
          end
          S_FRAME_B: state_d = S_TAIL;
          default: begin
            state_d  = S_IDLE;
            pend_a_d = 1'b0;
            pend_b_d = 1'b0;
          end
        endcase
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // Outputs are decoded from next state so the pins come straight from flops.
    in_frame_d = (state_d == S_FRAME_A) || (state_d == S_FRAME_B);
    sync_d     = !in_frame_d;
    sclk_d     = !in_frame_d || (div_d < DIV_W'(SCLK_DIVIDER / 2));
    din_d      = in_frame_d && sr_d[23];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      src_q    <= 1'b0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      rd_q     <= '0;
      sync_q   <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      src_q    <= src_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      rd_q     <= rd_d;
      sync_q   <= sync_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
    end
  end

  assign avsRdData = rd_q;
  assign dacSync   = sync_q;
  assign dacSclk   = sclk_q;
  assign dacDin    = din_q;

endmodule

// File: tb/tb_drv_ad56x3.sv
// tb/tb_drv_ad56x3.sv - self-checking bench for drv_ad56x3 with a frame-level reference model
// A pin monitor rebuilds 24-bit frames and sync gaps; directed and random steps compare them to the model.
`timescale 1ns/1ps
module tb_drv_ad56x3;
  localparam int DW       = 14;
  localparam int DIV      = 2;
  localparam int SYNC     = 5;
  localparam bit SIGNED_A = 1'b0;
  localparam bit SIGNED_B = 1'b1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    avsAdr = '0;
  logic          avsWr = 1'b0;
  logic [15:0]   avsWrData = '0;
  logic          avsRd = 1'b0;
  logic [15:0]   avsRdData;
  logic          asiValid0 = 1'b0, asiValid1 = 1'b0;
  logic [DW-1:0] asiData0 = '0, asiData1 = '0;
  logic          asiRdy0, asiRdy1;
  logic          dacSync, dacSclk, dacDin;

  int total = 0;
  int bad = 0;

  drv_ad56x3 #(
    .SIGN_A("UNSIGNED"), .SIGN_B("SIGNED"), .DATA_WIDTH(DW),
    .SCLK_DIVIDER(DIV), .SYNC_DURATION(SYNC)
  ) dut (
    .clk(clk), .reset(reset),
    .avsAdr(avsAdr), .avsWr(avsWr), .avsWrData(avsWrData), .avsRd(avsRd), .avsRdData(avsRdData),
    .asiValid0(asiValid0), .asiData0(asiData0), .asiRdy0(asiRdy0),
    .asiValid1(asiValid1), .asiData1(asiData1), .asiRdy1(asiRdy1),
    .dacSync(dacSync), .dacSclk(dacSclk), .dacDin(dacDin)
  );

  always #5 clk = ~clk;

  // Pin monitor: bits on dacSclk falling edges while dacSync is low; sync-high length between A and B.
  logic [23:0] frame_q[$];
  int          gap_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] shreg = '0;
  int          nbits = 0, hi_run = 0, sync_falls = 0, viol = 0;
  bit          in_pair = 1'b0;
  logic        prev_sclk = 1'b1, prev_sync = 1'b1, prev_din = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      nbits   = 0;
      in_pair = 1'b0;
      hi_run  = 0;
    end else begin
      if (prev_sync && !dacSync) begin
        sync_falls++;
        if (dacSclk !== 1'b1) viol++;
        if (in_pair) gap_q.push_back(hi_run);
      end
      if (dacDin !== prev_din && dacSclk !== 1'b1) viol++;
      if (prev_sclk && !dacSclk && !dacSync) begin
        shreg = {shreg[22:0], dacDin};
        nbits++;
        if (nbits == 24) begin
          frame_q.push_back(shreg);
          nbits   = 0;
          in_pair = !in_pair;
        end
      end
      hi_run = dacSync ? hi_run + 1 : 0;
    end
    prev_sclk = dacSclk;
    prev_sync = dacSync;
    prev_din  = dacDin;
  end

  function automatic logic [23:0] model_frame(input int ch, input int sample);
    int code;
    bit sgn;
    code = sample & ((1 << DW) - 1);
    sgn  = (ch == 0) ? SIGNED_A : SIGNED_B;
    if (sgn) code = code ^ (1 << (DW - 1));
    return 24'(((ch == 0 ? 0 : 2) << 19) | (ch << 16) | (code << (16 - DW)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mm_write(input logic [2:0] a, input logic [15:0] d);
    avsAdr = a; avsWrData = d; avsWr = 1'b1;
    tick(1);
    avsWr = 1'b0;
  endtask

  task automatic mm_read(input logic [2:0] a, output logic [15:0] d);
    avsAdr = a; avsRd = 1'b1;
    tick(1);
    d = avsRdData;
    avsRd = 1'b0;
  endtask

  task automatic wait_both_rdy(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (asiRdy0 && asiRdy1) begin ok = 1'b1; break; end
      tick(1);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_frames(input string tag, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (frame_q.size() >= n) begin ok = 1'b1; break; end
      tick(1);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, 32'(frame_q.size()), 32'(exp_q.size()));
    while (frame_q.size() > 0 && exp_q.size() > 0)
      chk(tag, 32'(frame_q.pop_front()), 32'(exp_q.pop_front()));
    while (gap_q.size() > 0)
      chk({tag, "_gap"}, 32'(gap_q.pop_front()), 32'(DIV * SYNC));
    frame_q.delete();
    exp_q.delete();
  endtask

  task automatic send_pair(input int a, input int b);
    asiData0 = DW'(a); asiData1 = DW'(b);
    asiValid0 = 1'b1; asiValid1 = 1'b1;
    tick(1);
    asiValid0 = 1'b0; asiValid1 = 1'b0;
    exp_q.push_back(model_frame(0, a));
    exp_q.push_back(model_frame(1, b));
  endtask

  initial begin
    logic [15:0] rd;
    int a, b, cnt, f0;
    bit seen;

    #12;
    chk("rst_sync", 32'(dacSync), 32'd1);
    chk("rst_sclk", 32'(dacSclk), 32'd1);
    chk("rst_din", 32'(dacDin), 32'd0);
    chk("rst_rddata", 32'(avsRdData), 32'd0);
    #10 reset = 1'b0;
    tick(1);
    chk("rdy0_after_rst", 32'(asiRdy0), 32'd1);
    chk("rdy1_after_rst", 32'(asiRdy1), 32'd1);
    mm_read(3'd0, rd);
    chk("ctrl_rst", 32'(rd), 32'd0);

    // Reference pair and the sync-fall to rdy-rise latency.
    send_pair(32'h1234, 32'h2ABC);
    chk("rdy0_drop", 32'(asiRdy0), 32'd0);
    chk("rdy1_drop", 32'(asiRdy1), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!dacSync) begin seen = 1'b1; break; end
      tick(1);
    end
    chk("sync_fall", 32'(seen), 32'd1);
    cnt = 0;
    while (!asiRdy0 && cnt < 300) begin tick(1); cnt++; end
    chk("seq_len", 32'(cnt), 32'(DIV * (48 + SYNC + 1)));
    chk("rdy1_with_rdy0", 32'(asiRdy1), 32'd1);
    wait_frames("ref_frames", 2);
    chk("ref_frame_a", 32'(frame_q[0]), 32'h0048D0);
    chk("ref_frame_b", 32'(frame_q[1]), 32'h112AF0);
    check_frames("ref");

    // Channel A alone must not start a sequence.
    a = int'($urandom);
    asiData0 = DW'(a); asiValid0 = 1'b1;
    tick(1);
    asiValid0 = 1'b0;
    chk("a_only_rdy0", 32'(asiRdy0), 32'd0);
    chk("a_only_rdy1", 32'(asiRdy1), 32'd1);
    f0 = sync_falls;
    tick(40);
    chk("a_only_nosync", 32'(sync_falls), 32'(f0));
    mm_read(3'd3, rd);
    chk("a_only_busy", 32'(rd), 32'd0);
    b = int'($urandom);
    asiData1 = DW'(b); asiValid1 = 1'b1;
    tick(1);
    asiValid1 = 1'b0;
    exp_q.push_back(model_frame(0, a));
    exp_q.push_back(model_frame(1, b));
    wait_frames("a_then_b_frames", 2);
    wait_both_rdy("a_then_b_rdy");
    check_frames("a_then_b");

    // Continuous random pairs; junk is presented while rdy is low and must be ignored.
    for (int k = 0; k < 6; k++) begin
      a = int'($urandom);
      b = int'($urandom);
      asiValid0 = 1'b1; asiValid1 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (asiRdy0 && asiRdy1) begin
          asiData0 = DW'(a); asiData1 = DW'(b);
          tick(1);
          seen = 1'b1;
          break;
        end
        asiData0 = DW'($urandom); asiData1 = DW'($urandom);
        tick(1);
      end
      asiValid0 = 1'b0; asiValid1 = 1'b0;
      chk("rand_capture", 32'(seen), 32'd1);
      exp_q.push_back(model_frame(0, a));
      exp_q.push_back(model_frame(1, b));
    end
    wait_both_rdy("rand_done");
    check_frames("rand");

    // MM source with BUSY polling.
    mm_write(3'd0, 16'h0001);
    chk("mm_rdy0", 32'(asiRdy0), 32'd0);
    chk("mm_rdy1", 32'(asiRdy1), 32'd0);
    mm_write(3'd1, 16'h0000);
    mm_write(3'd2, 16'h2000);
    tick(5);
    mm_read(3'd3, rd);
    chk("mm_busy1", 32'(rd), 32'd1);
    wait_frames("mm_frames", 2);
    tick(10);
    mm_read(3'd3, rd);
    chk("mm_busy0", 32'(rd), 32'd0);
    chk("mm_frame_a", 32'(frame_q[0]), 32'h000000);
    chk("mm_frame_b", 32'(frame_q[1]), 32'h110000);
    exp_q.push_back(24'h000000);
    exp_q.push_back(24'h110000);
    check_frames("mm");
    mm_read(3'd0, rd);
    chk("mm_ctrl", 32'(rd), 32'd1);
    mm_read(3'd5, rd);
    chk("unmapped_read", 32'(rd), 32'd0);

    // Pending A from MM survives the switch back to streaming.
    a = int'($urandom);
    mm_write(3'd1, 16'(a));
    mm_write(3'd0, 16'h0000);
    chk("keep_rdy0", 32'(asiRdy0), 32'd0);
    chk("keep_rdy1", 32'(asiRdy1), 32'd1);
    b = int'($urandom);
    asiData1 = DW'(b); asiValid1 = 1'b1;
    tick(1);
    asiValid1 = 1'b0;
    exp_q.push_back(model_frame(0, a));
    exp_q.push_back(model_frame(1, b));
    wait_frames("keep_frames", 2);
    wait_both_rdy("keep_rdy");
    check_frames("keep");

    // Reset in the middle of frame B.
    send_pair(int'($urandom), int'($urandom));
    wait_frames("abort_frame_a", 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!dacSync) begin seen = 1'b1; break; end
      tick(1);
    end
    chk("abort_in_b", 32'(seen), 32'd1);
    tick(7);
    #2 reset = 1'b1;
    #1;
    chk("abort_sync", 32'(dacSync), 32'd1);
    chk("abort_sclk", 32'(dacSclk), 32'd1);
    chk("abort_din", 32'(dacDin), 32'd0);
    tick(2);
    #3 reset = 1'b0;
    tick(1);
    chk("abort_rdy0", 32'(asiRdy0), 32'd1);
    chk("abort_rdy1", 32'(asiRdy1), 32'd1);
    mm_read(3'd3, rd);
    chk("abort_busy", 32'(rd), 32'd0);
    frame_q.delete();
    gap_q.delete();
    exp_q.delete();

    send_pair(int'($urandom), int'($urandom));
    wait_frames("recover_frames", 2);
    wait_both_rdy("recover_rdy");
    check_frames("recover");
    chk("din_sync_timing", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
